// File: rtl/hub75_fb_scheduler_pkg.sv
// Shared types and default widths for the HUB75 frame-buffer write scheduler.
package hub75_pkg;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {IDLE, FILL} fill_state_e;
    typedef enum logic {GNT_CPU, GNT_FILL} gnt_e;
endpackage

// File: rtl/hub75_fb_scheduler_if.sv
// CPU write channel in, pixel-memory write port out.
interface hub75_fb_scheduler_if #(
    parameter int ADDR_W = hub75_pkg::DEF_ADDR_W,
    parameter int DATA_W = hub75_pkg::DEF_DATA_W
);
    logic              cpu_wr_valid;
    logic              cpu_wr_ready;
    logic [ADDR_W-2:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
        input  cpu_wr_ready, mem_wr, mem_waddr, mem_wdata
    );
    modport slave (
        input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
        output cpu_wr_ready, mem_wr, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/hub75_fb_scheduler_arb.sv
// Two-requester round-robin arbiter; history only advances on conflicts.
module hub75_rr_arb2
    import hub75_pkg::*;
(
    input  logic pclk,
    input  logic presetn,
    input  logic req_cpu,
    input  logic req_fill,
    output logic gnt_cpu,
    output logic gnt_fill
);
    gnt_e last_grant;
    logic conflict;

    assign conflict = req_cpu & req_fill;
    assign gnt_cpu  = req_cpu  & (~req_fill | (last_grant == GNT_FILL));
    assign gnt_fill = req_fill & (~req_cpu  | (last_grant == GNT_CPU));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)
            last_grant <= GNT_FILL;
        else if (conflict)
            last_grant <= gnt_cpu ? GNT_CPU : GNT_FILL;
    end
endmodule

// File: rtl/hub75_fb_scheduler.sv
// Back-bank write scheduler: CPU/fill arbitration and frame-aligned bank swap.
module hub75_fb_scheduler
    import hub75_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                 pclk,
    input  logic                 presetn,
    hub75_fb_scheduler_if.slave  bus,
    input  logic                 fill_start,
    input  logic [DATA_W-1:0]    fill_value,
    input  logic [ADDR_W-2:0]    fill_len,
    output logic                 fill_busy,
    output logic                 fill_done,
    input  logic                 swap_req,
    output logic                 swap_pending,
    input  logic                 frame_sync,
    output logic                 front_bank
);
    fill_state_e       state;
    logic [DATA_W-1:0] fill_val;
    logic [ADDR_W-2:0] fill_len_q;
    logic [ADDR_W-2:0] fill_ptr;
    logic              gnt_cpu, gnt_fill;
    logic              fs_q, swap_go;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    hub75_rr_arb2 u_arb (
        .pclk     (pclk),
        .presetn  (presetn),
        .req_cpu  (bus.cpu_wr_valid),
        .req_fill (state == FILL),
        .gnt_cpu  (gnt_cpu),
        .gnt_fill (gnt_fill)
    );

    assign bus.cpu_wr_ready = bus.cpu_wr_valid & gnt_cpu;
    assign bus.mem_wr       = mem_wr;
    assign bus.mem_waddr    = mem_waddr;
    assign bus.mem_wdata    = mem_wdata;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state        <= IDLE;
            fill_val     <= '0;
            fill_len_q   <= '0;
            fill_ptr     <= '0;
            fill_busy    <= 1'b0;
            fill_done    <= 1'b0;
            mem_wr       <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
            fs_q         <= 1'b0;
            swap_go      <= 1'b0;
            swap_pending <= 1'b0;
            front_bank   <= 1'b0;
        end else begin
            fill_done <= 1'b0;
            mem_wr    <= gnt_cpu | gnt_fill;
            if (gnt_cpu) begin
                mem_waddr <= {~front_bank, bus.cpu_wr_addr};
                mem_wdata <= bus.cpu_wr_data;
            end else if (gnt_fill) begin
                mem_waddr <= {~front_bank, fill_ptr};
                mem_wdata <= fill_val;
            end

            case (state)
                IDLE: if (fill_start) begin
                    if (fill_len != '0) begin
                        state      <= FILL;
                        fill_val   <= fill_value;
                        fill_len_q <= fill_len;
                        fill_ptr   <= '0;
                        fill_busy  <= 1'b1;
                    end else begin
                        fill_done  <= 1'b1;
                    end
                end
                FILL: if (gnt_fill) begin
                    fill_ptr <= fill_ptr + 1'b1;
                    // busy/done drop alongside the final word on mem_wr
                    if (fill_ptr == fill_len_q - 1'b1) begin
                        state     <= IDLE;
                        fill_busy <= 1'b0;
                        fill_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Qualify with pending/busy as seen at the edge, so a swap_req
            // arriving on the edge cycle waits for the next frame.
            fs_q    <= frame_sync;
            swap_go <= frame_sync & ~fs_q & swap_pending & ~fill_busy;
            if (swap_go) begin
                front_bank   <= ~front_bank;
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hub75_fb_scheduler.sv
// Directed bench for hub75_fb_scheduler with hand-computed expectations.
module tb_hub75_fb_scheduler;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;

    logic              pclk = 1'b0;
    logic              presetn = 1'b0;
    logic              fill_start = 1'b0;
    logic [DATA_W-1:0] fill_value = '0;
    logic [ADDR_W-2:0] fill_len = '0;
    logic              fill_busy, fill_done;
    logic              swap_req = 1'b0;
    logic              swap_pending;
    logic              frame_sync = 1'b0;
    logic              front_bank;
    int                checks = 0;
    int                errors = 0;

    hub75_fb_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    hub75_fb_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .pclk         (pclk),
        .presetn      (presetn),
        .bus          (bus),
        .fill_start   (fill_start),
        .fill_value   (fill_value),
        .fill_len     (fill_len),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .frame_sync   (frame_sync),
        .front_bank   (front_bank)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #2;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_front"},   front_bank,    0);
        chk({tag, "_pending"}, swap_pending,  0);
        chk({tag, "_busy"},    fill_busy,     0);
        chk({tag, "_done"},    fill_done,     0);
        chk({tag, "_wr"},      bus.mem_wr,    0);
        chk({tag, "_waddr"},   bus.mem_waddr, 0);
        chk({tag, "_wdata"},   bus.mem_wdata, 0);
    endtask

    initial begin
        int j;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        bus.cpu_wr_valid = 1'b0;
        bus.cpu_wr_addr  = '0;
        bus.cpu_wr_data  = '0;

        #12;
        chk_reset_vals("rst");
        presetn = 1'b1;
        step();

        // CPU-only write into back bank 1
        bus.cpu_wr_valid = 1'b1;
        bus.cpu_wr_addr  = 14'h010;
        bus.cpu_wr_data  = 32'hDEADBEEF;
        #1;
        chk("cpu_ready", bus.cpu_wr_ready, 1);
        step();
        bus.cpu_wr_valid = 1'b0;
        chk("cpu_wr",    bus.mem_wr,    1);
        chk("cpu_waddr", bus.mem_waddr, 15'h4010);
        chk("cpu_wdata", bus.mem_wdata, 32'hDEADBEEF);
        step();
        chk("cpu_wr_once", bus.mem_wr, 0);

        // Uncontended fill of 4 words
        fill_start = 1'b1; fill_len = 14'd4; fill_value = 32'h00FF00FF;
        step();
        fill_start = 1'b0;
        chk("fill_busy_set", fill_busy, 1);
        chk("fill_nowr_yet", bus.mem_wr, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fill_wr",    bus.mem_wr,    1);
            chk("fill_waddr", bus.mem_waddr, 15'h4000 + 15'(i));
            chk("fill_wdata", bus.mem_wdata, 32'h00FF00FF);
            chk("fill_done",  fill_done,     (i == 3) ? 1 : 0);
            chk("fill_busy",  fill_busy,     (i == 3) ? 0 : 1);
        end
        step();
        chk("fill_end_wr",   bus.mem_wr, 0);
        chk("fill_end_done", fill_done,  0);

        // Contention: CPU saturating while filling 3 words
        fill_start = 1'b1; fill_len = 14'd3; fill_value = 32'h0F0F0F0F;
        step();
        fill_start = 1'b0;
        j = 0;
        bus.cpu_wr_valid = 1'b1;
        bus.cpu_wr_addr  = 14'h100;
        bus.cpu_wr_data  = 32'hC0DE0000;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("cont_ready", bus.cpu_wr_ready, (k % 2 == 0) ? 1 : 0);
            if (k % 2 == 0) begin
                ea = {1'b1, 14'h100 + 14'(j)};
                ed = 32'hC0DE0000 + 32'(j);
                j++;
            end else begin
                ea = 15'h4000 + 15'(k / 2);
                ed = 32'h0F0F0F0F;
            end
            step();
            chk("cont_wr",    bus.mem_wr,    1);
            chk("cont_waddr", bus.mem_waddr, ea);
            chk("cont_wdata", bus.mem_wdata, ed);
            chk("cont_done",  fill_done,     (k == 5) ? 1 : 0);
            bus.cpu_wr_addr = 14'h100 + 14'(j);
            bus.cpu_wr_data = 32'hC0DE0000 + 32'(j);
        end
        bus.cpu_wr_valid = 1'b0;
        chk("cont_cpu_words", j, 3);
        step();
        chk("cont_idle_wr", bus.mem_wr, 0);

        // Swap deferred while a fill is running
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("swap_pending_set", swap_pending, 1);
        fill_start = 1'b1; fill_len = 14'd4; fill_value = 32'hA5A5A5A5;
        step();
        fill_start = 1'b0;
        chk("swap_busy", fill_busy, 1);
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        step();
        chk("swap_deferred_front",   front_bank,   0);
        chk("swap_deferred_pending", swap_pending, 1);
        for (int i = 0; i < 20 && fill_done !== 1'b1; i++) step();
        chk("swap_fill_done", fill_done, 1);
        step();
        frame_sync = 1'b1;
        step();
        chk("swap_front_e1", front_bank, 0);
        step();
        chk("swap_front_e2",  front_bank,   1);
        chk("swap_cleared",   swap_pending, 0);
        frame_sync = 1'b0;

        // After swap, bank 0 is the back bank
        bus.cpu_wr_valid = 1'b1;
        bus.cpu_wr_addr  = 14'h010;
        bus.cpu_wr_data  = 32'h12345678;
        step();
        bus.cpu_wr_valid = 1'b0;
        chk("bank0_waddr", bus.mem_waddr, 15'h0010);
        chk("bank0_wdata", bus.mem_wdata, 32'h12345678);

        // Zero-length fill
        fill_start = 1'b1; fill_len = 14'd0;
        step();
        fill_start = 1'b0;
        chk("zero_done", fill_done,  1);
        chk("zero_busy", fill_busy,  0);
        chk("zero_wr",   bus.mem_wr, 0);
        step();
        chk("zero_done_pulse", fill_done,  0);
        chk("zero_wr2",        bus.mem_wr, 0);

        // swap_req coinciding with a frame_sync edge
        frame_sync = 1'b1; swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        chk("same_pending", swap_pending, 1);
        step();
        chk("same_no_swap", front_bank, 1);
        frame_sync = 1'b0;
        step();
        step();
        chk("same_still_front", front_bank, 1);
        frame_sync = 1'b1;
        step();
        step();
        chk("same_next_front",   front_bank,   0);
        chk("same_next_pending", swap_pending, 0);
        frame_sync = 1'b0;

        // Reset mid-fill with a swap pending
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        fill_start = 1'b1; fill_len = 14'd10; fill_value = 32'h55AA55AA;
        step();
        fill_start = 1'b0;
        step();
        chk("midfill_wr", bus.mem_wr, 1);
        presetn = 1'b0;
        #1;
        chk_reset_vals("rst_async");
        step();
        chk_reset_vals("rst_hold");
        presetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_post_wr",   bus.mem_wr, 0);
            chk("rst_post_busy", fill_busy,  0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hub75_fb_scheduler.md
# hub75_fb_scheduler

Write-side scheduler for the HUB75 pixel memory. It shares the single pixel-memory write port between the CPU write path (`apb_ctrl_status` mem_* outputs) and an internal fill/clear engine, using round-robin arbitration. It also double-buffers the memory as front/back banks and swaps banks only on a display frame boundary, so the panel never shows a partially drawn frame. It sits between `apb_ctrl_status` and `H75_MODULE` inside CAPE.

## Interface
- ADDR_W, 15, pixel-memory word address width; MSB is the bank bit.
- DATA_W, 32, pixel word width.
- pclk  in  1  system clock; all logic is on its rising edge.
- presetn  in  1  reset, asynchronous, active-low.
- cpu_wr_valid  in  1  CPU write request.
- cpu_wr_ready  out  1  combinational; CPU write accepted this cycle.
- cpu_wr_addr  in  ADDR_W-1  word offset inside the back bank.
- cpu_wr_data  in  DATA_W  CPU write data.
- fill_start  in  1  single-cycle pulse; start a fill of the back bank.
- fill_value  in  DATA_W  word written by the fill; sampled at fill_start.
- fill_len  in  ADDR_W-1  number of words to fill, from offset 0; sampled at fill_start.
- fill_busy  out  1  fill engine active.
- fill_done  out  1  single-cycle pulse marking fill completion.
- swap_req  in  1  single-cycle pulse; request a bank swap.
- swap_pending  out  1  swap requested, not yet applied.
- frame_sync  in  1  frame marker from H75_MODULE; pclk-synchronous level.
- front_bank  out  1  bank the display reads; drives the read-address MSB.
- mem_wr, mem_waddr[ADDR_W], mem_wdata[DATA_W]  out  registered write port to H75_MODULE.

## Operation
- Reset values: front_bank=0, swap_pending=0, fill_busy=0, fill_done=0, mem_wr=0, mem_waddr=0, mem_wdata=0, FSM=IDLE, last_grant=FILL.
- All writes target the back bank: mem_waddr = {~front_bank, offset}.
  - The bank bit is taken from front_bank in the grant cycle.
- Fill FSM states:
  - IDLE → FILL on fill_start with fill_len≠0. Latch value and length, set fill_ptr=0, fill_busy=1.
  - fill_start with fill_len=0 produces no writes. fill_done pulses the next cycle and fill_busy stays 0.
  - fill_start while FILL is ignored.
  - In FILL, the engine requests every cycle. On each grant it writes fill_ptr and increments it.
  - The grant for fill_ptr=len-1 returns the FSM to IDLE.
- Arbitration (2 requesters: CPU, FILL):
  - A lone requester is granted.
  - On conflict, the requester not granted last wins. last_grant updates only on conflicting cycles.
  - cpu_wr_ready = cpu_wr_valid & grant_cpu.
  - At most one write per cycle; no write is ever dropped.
- Swap:
  - swap_req sets swap_pending. A repeated swap_req while pending has no extra effect.
  - Rising edge of frame_sync (registered edge detect) with swap_pending=1 and fill_busy=0: toggle front_bank, clear swap_pending.
  - If fill_busy=1 at the edge, the swap waits for a later edge.
  - swap_req in the same cycle as an edge only becomes pending; it applies at the next edge.
- Reset mid-fill or mid-swap returns everything to reset values at once. No trailing mem_wr is issued.

## Timing
- Grant in cycle N → mem_wr/mem_waddr/mem_wdata valid in cycle N+1, for exactly one cycle.
- Fill throughput:
  - Uncontended: fill_len writes take fill_len cycles.
  - With CPU saturating the port: alternating grants, 2·fill_len cycles at most.
- fill_busy falls, and fill_done pulses, in the cycle the last fill write appears on mem_wr.
- front_bank changes 2 cycles after the frame_sync rising edge: 1 cycle for edge detect, 1 cycle register.
- Offset arithmetic is unsigned ADDR_W-1 bits; fill_len ≤ 2^(ADDR_W-1)-1. A full-bank fill is therefore impossible by construction, and fill_ptr never wraps.

## Structure
- hub75_pkg holds:
  - ADDR_W and DATA_W defaults;
  - the fill FSM state enum {IDLE, FILL};
  - the grant enum {GNT_CPU, GNT_FILL}.
- Sub-module hub75_rr_arb2 is a 2-requester round-robin arbiter with the last_grant register. The fill FSM, swap logic and output registers stay in the top module.

## Test plan
- Reset: hold presetn low mid-fill → all outputs at reset values within the reset; no mem_wr after release until a new request.
- CPU only: write offset 0x010, data 0xDEADBEEF, front_bank=0 → next cycle mem_wr=1, mem_waddr=0x4010, mem_wdata=0xDEADBEEF.
- Fill uncontended: fill_len=4, fill_value=0x00FF00FF → 4 consecutive writes to 0x4000..0x4003; fill_done coincides with the 0x4003 write.
- Contention: fill_len=3 with cpu_wr_valid held high → CPU wins first, then grants alternate C,F,C,F,C,F; the fill finishes in 6 cycles; every accepted CPU word appears exactly once.
- Swap deferral: swap_req, then frame_sync edge while fill_busy=1 → no swap. Next edge after fill_done → front_bank=1 two cycles after the edge, and swap_pending=0.
- Edge cases:
  - fill_len=0 → no writes, one fill_done pulse.
  - swap_req in the same cycle as a frame_sync edge → swap only at the following edge.
